// File: rtl/signed_to_bcd.sv
// Signed 8-bit to sign + 3-digit BCD converter using shift-and-add-3, one bit per clock.
// Digits and sign are registered only at completion, so the display never sees partial results.
//
// state | meaning
// IDLE  | waiting for start_i; last result held on outputs
// CONV  | eight shift-and-add-3 steps in progress
module signed_to_bcd (
  input  logic       clk_i,
  input  logic       rst_n_i,
  input  logic       start_i,
  input  logic [7:0] ai_i,
  output logic       busy_o,
  output logic       done_o,
  output logic       sign_o,
  output logic [3:0] hund_o,
  output logic [3:0] tens_o,
  output logic [3:0] ones_o
);

  typedef enum logic {IDLE, CONV} state_t;

  state_t      state_q, state_d;
  logic [2:0]  cnt_q, cnt_d;
  logic [19:0] work_q, work_d;
  logic        sign_cap_q, sign_cap_d;
  logic        done_q, done_d;
  logic        sign_q, sign_d;
  logic [3:0]  hund_q, hund_d;
  logic [3:0]  tens_q, tens_d;
  logic [3:0]  ones_q, ones_d;

  logic [7:0]  mag;
  logic [11:0] bcd_adj;
  logic [19:0] shifted;

  function automatic logic [3:0] add3(input logic [3:0] n);
    return (n >= 4'd5) ? n + 4'd3 : n;
  endfunction

  always_comb begin
    // 0x80 negates to itself and is read as unsigned 128
    mag     = ai_i[7] ? (~ai_i + 8'd1) : ai_i;
    bcd_adj = {add3(work_q[19:16]), add3(work_q[15:12]), add3(work_q[11:8])};
    shifted = {bcd_adj[10:0], work_q[7:0], 1'b0};
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    work_d     = work_q;
    sign_cap_d = sign_cap_q;
    done_d     = 1'b0;
    sign_d     = sign_q;
    hund_d     = hund_q;
    tens_d     = tens_q;
    ones_d     = ones_q;
    unique case (state_q)
      IDLE: begin
        if (start_i) begin
          sign_cap_d = ai_i[7];
          work_d     = {12'd0, mag};
          cnt_d      = 3'd0;
          state_d    = CONV;
        end
      end
      CONV: begin
        work_d = shifted;
        cnt_d  = cnt_q + 3'd1;
        if (cnt_q == 3'd7) begin
          hund_d  = shifted[19:16];
          tens_d  = shifted[15:12];
          ones_d  = shifted[11:8];
          sign_d  = sign_cap_q;
          done_d  = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      state_q    <= IDLE;
      cnt_q      <= 3'd0;
      work_q     <= 20'd0;
      sign_cap_q <= 1'b0;
      done_q     <= 1'b0;
      sign_q     <= 1'b0;
      hund_q     <= 4'd0;
      tens_q     <= 4'd0;
      ones_q     <= 4'd0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      work_q     <= work_d;
      sign_cap_q <= sign_cap_d;
      done_q     <= done_d;
      sign_q     <= sign_d;
      hund_q     <= hund_d;
      tens_q     <= tens_d;
      ones_q     <= ones_d;
    end
  end

  assign busy_o = (state_q == CONV);
  assign done_o = done_q;
  assign sign_o = sign_q;
  assign hund_o = hund_q;
  assign tens_o = tens_q;
  assign ones_o = ones_q;

endmodule

// File: doc/signed_to_bcd.md
# signed_to_bcd

Sequential converter that takes an 8-bit two's-complement value, forms its magnitude and sign, and converts the magnitude to three BCD digits using the shift-and-add-3 (double dabble) algorithm, one bit per clock. It sits downstream of the team's two's-complement/magnitude logic and feeds the seven-segment display drivers. Each conversion is started by a one-cycle request and completes with a one-cycle done pulse.

## Interface
- No parameters; the width is fixed at 8 bits in and 3 BCD digits out.
- Clk  input  1  sole clock; all state changes on the rising edge.
- Rst_n  input  1  reset; synchronous and active-low.
- Start  input  1  conversion request; sampled only while idle.
- Ai  input  8  signed two's-complement operand; captured on the accepting edge.
- Busy  output  1  high while a conversion is in progress.
- Done  output  1  one-cycle pulse when the outputs below update.
- Sign  output  1  1 = operand was negative.
- Hund  output  4  BCD hundreds digit, range 0–1.
- Tens  output  4  BCD tens digit, range 0–9.
- Ones  output  4  BCD ones digit, range 0–9.

## Operation
- Two states: IDLE and CONV. Bit counter is 3 bits. Working register is 20 bits: 12-bit BCD field plus 8-bit binary field.
- **IDLE, Start=1:**
  - Capture Sign = Ai[7].
  - Magnitude = Ai[7] ? (~Ai + 1) : Ai, taken modulo 256.
  - 0x80 gives magnitude 0x80, which is interpreted as unsigned 128.
  - Load the binary field with the magnitude and clear the BCD field.
  - Set counter = 0 and go to CONV.
- **IDLE, Start=0:** hold.
- **CONV, each edge:**
  - For each BCD nibble of the working register, add 3 if the nibble is ≥5.
  - Shift the whole 20-bit register left by 1.
  - Increment the counter.
- **Counter at 7 on an edge (8th shift):**
  - Load Hund/Tens/Ones from the post-shift BCD field.
  - Load the registered Sign output from the captured sign.
  - Pulse Done and return to IDLE.
- Start while in CONV is ignored. It is not queued.
- Hund, Tens, Ones and Sign hold their last values until the next Done. They never show intermediate values.
- Sign for zero is 0. There is no negative zero.

## Timing
- **Reset (Rst_n=0 at an edge):**
  - State goes to IDLE and the counter to 0.
  - Busy=0, Done=0, Sign=0, Hund=0, Tens=0, Ones=0.
  - Reset overrides Start.
- **Reset mid-conversion:** the conversion is aborted. No Done is produced and the outputs read 0.
- **Latency:** Start accepted at edge k.
  - Busy=1 from after edge k until edge k+8.
  - Final shift happens at edge k+8. Digits, Sign and Done=1 are registered at that edge, and Busy drops at the same edge.
  - Done stays high for exactly one cycle (edges k+8 to k+9).
- **Back-to-back:** Start held high or reasserted during the Done cycle is accepted at edge k+9. Sustained throughput is one conversion per 9 cycles.
- **Start held high continuously:** a new conversion starts every 9 cycles. Each produces its own Done.
- **Ai:** only sampled on the accepting edge; changes during CONV have no effect.
- All outputs are registered, with no combinational path from inputs to outputs.

## Test plan
- Assert reset, then Start with Ai=0x00 → Done 8 cycles after accept; Sign=0, Hund=0, Tens=0, Ones=0.
- Ai=0x7F (127), then Ai=0x9C (−100) → 0,1,2,7; then 1,1,0,0. Each is checked at its Done pulse, and Busy stays high for exactly 8 cycles per conversion.
- Ai=0x80 (−128) and Ai=0xFF (−1) → Sign=1 with digits 1,2,8; Sign=1 with digits 0,0,1.
- Start Ai=0x2A, pulse Start again with Ai=0x05 at cycle 3 of CONV → only one Done, with digits 0,4,2. The second Start is ignored.
- Start Ai=0x63 (99), drive Rst_n=0 at cycle 4 of CONV → no Done; all outputs 0 after the reset edge; a fresh Start with Ai=0x0A gives 0,1,0.
- Start held high with Ai alternating 0x01 / 0xF6 at each accept → Done every 9 cycles; digits alternate between Sign=0, 0,0,1 and Sign=1, 0,1,0.
